// File: rtl/ula_result_fifo.sv
// ula_result_fifo: first-word-fall-through result FIFO behind sequential_basic_ula.
// Every valid ULA result (word + carry-out) is captured and handed to a consumer
// over valid/ready. Occupancy, full/empty and a sticky overflow flag are reported.
// Optional feature macro: ULA_RFIFO_WATERMARK_EN adds o_max_level (peak occupancy).
module ula_result_fifo #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_data_valid,
    input  logic [DATA_W-1:0] i_data_result,
    input  logic              i_data_carryout,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_result,
    output logic              o_rd_carryout,
    output logic [AW:0]       o_level,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
`ifdef ULA_RFIFO_WATERMARK_EN
    output logic [AW:0]       o_max_level,
`endif
    input  logic              i_clr_overflow
);

    // One stored result: carry sits above the result word.
    typedef struct packed {
        logic              carry;
        logic [DATA_W-1:0] result;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_overflow;

    logic [AW:0]   w_level;
    logic [AW:0]   w_level_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    entry_t        w_head;

    // Pointers carry one extra wrap bit, so occupancy is a plain difference
    // and full/empty are unambiguous without a separate counter.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == (AW+1)'(DEPTH));
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // A pop frees a slot this same edge, so a push at full is still accepted
    // when the head is leaving.
    assign w_pop  = !w_empty && i_rd_ready;
    assign w_push = i_data_valid && (!w_full || w_pop);
    assign w_drop = i_data_valid && w_full && !w_pop;

    assign w_level_nxt = w_level + (AW+1)'(w_push) - (AW+1)'(w_pop);

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= '{carry: i_data_carryout, result: i_data_result};
    end

    // Pointer update; reset wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky overflow: a dropped write sets it, clear only takes effect when
    // no drop happens on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (i_clr_overflow)
            r_overflow <= 1'b0;
    end

`ifdef ULA_RFIFO_WATERMARK_EN
    logic [AW:0] r_max_level;

    // Peak occupancy tracker; a clear restarts it, keeping a level rise
    // that lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            r_max_level <= '0;
        else if (i_clr_overflow)
            r_max_level <= (w_push && !w_pop) ? w_level_nxt : '0;
        else if (w_level_nxt > r_max_level)
            r_max_level <= w_level_nxt;
    end

    assign o_max_level = r_max_level;
`else
    // Next level is only consumed by the watermark tracker.
    logic w_unused;
    assign w_unused = ^w_level_nxt;
`endif

    // Head entry falls straight through from the array; zeroed when empty.
    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign o_rd_valid    = !w_empty;
    assign o_rd_result   = w_empty ? '0   : w_head.result;
    assign o_rd_carryout = w_empty ? 1'b0 : w_head.carry;

    assign o_level    = w_level;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule
